// File: rtl/fft32_result_reader.sv
// Snapshots the fft32 parallel output bus a fixed latency after `start` and streams it out bin by bin.
// Optional FFT_RD_TWOS_EN converts each sign-magnitude half of m_data to two's complement.
module fft32_result_reader #(
    parameter int NPTS    = 32,
    parameter int WW      = 48,
    parameter int FFT_LAT = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [NPTS*WW-1:0]       xw_flat,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [WW-1:0]            m_data,
    output logic [$clog2(NPTS)-1:0]  m_index,
    output logic                     m_last,
    output logic                     busy,
    output logic                     overrun
);
    localparam int IW = $clog2(NPTS);
    localparam int HW = WW / 2;
    localparam logic [7:0]    LAT_INIT = 8'(FFT_LAT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NPTS - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STREAM} state_t;

    state_t        state;
    logic          start_q;
    logic          rise;
    logic [7:0]    lat_cnt;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_next;
    logic [WW-1:0] frame_buf [NPTS];

`ifdef FFT_RD_TWOS_EN
    function automatic logic [HW-1:0] to_twos(input logic [HW-1:0] h);
        logic [HW-1:0] mag;
        mag = {1'b0, h[HW-2:0]};
        return h[HW-1] ? ('0 - mag) : mag;
    endfunction

    function automatic logic [WW-1:0] rd_conv(input logic [WW-1:0] w);
        return {to_twos(w[WW-1 -: HW]), to_twos(w[HW-1:0])};
    endfunction
`else
    function automatic logic [WW-1:0] rd_conv(input logic [WW-1:0] w);
        return w;
    endfunction
`endif

    always_comb begin
        rise     = start & ~start_q;
        idx_next = idx + 1'b1;
    end

    assign m_index = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            start_q <= 1'b0;
            lat_cnt <= '0;
            idx     <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
            for (int unsigned k = 0; k < NPTS; k++) begin
                frame_buf[k] <= '0;
            end
        end else begin
            start_q <= start;
            overrun <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rise) begin
                        lat_cnt <= LAT_INIT;
                        busy    <= 1'b1;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    overrun <= rise;
                    if (lat_cnt == '0) begin
                        for (int unsigned k = 0; k < NPTS; k++) begin
                            frame_buf[k] <= xw_flat[k*WW +: WW];
                        end
                        // First word comes straight from the bus; the buffer is not yet loaded.
                        m_data  <= rd_conv(xw_flat[0 +: WW]);
                        m_last  <= (NPTS == 1);
                        idx     <= '0;
                        m_valid <= 1'b1;
                        state   <= S_STREAM;
                    end else begin
                        lat_cnt <= lat_cnt - 8'd1;
                    end
                end
                S_STREAM: begin
                    // A rise coinciding with the final handshake still counts as overrun.
                    overrun <= rise;
                    if (m_ready) begin
                        if (idx == LAST_IDX) begin
                            m_valid <= 1'b0;
                            m_data  <= '0;
                            m_last  <= 1'b0;
                            idx     <= '0;
                            busy    <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            idx    <= idx_next;
                            m_data <= rd_conv(frame_buf[idx_next]);
                            m_last <= (idx_next == LAST_IDX);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft32_result_reader.sv
// Self-checking bench for fft32_result_reader: random frames checked against an arithmetic model.
// Define FFT_RD_TWOS_EN for both files to exercise the two's-complement read path.
module tb_fft32_result_reader;
    localparam int NPTS    = 32;
    localparam int WW      = 48;
    localparam int FFT_LAT = 6;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [NPTS*WW-1:0]  xw_flat;
    logic                m_valid;
    logic                m_ready;
    logic [WW-1:0]       m_data;
    logic [4:0]          m_index;
    logic                m_last;
    logic                busy;
    logic                overrun;

    int errors = 0;
    int checks = 0;

    logic [WW-1:0] exp_w [NPTS];
    logic [WW-1:0] obs_w [NPTS];

    fft32_result_reader #(.NPTS(NPTS), .WW(WW), .FFT_LAT(FFT_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .xw_flat(xw_flat),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
        .m_last(m_last), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: sign-magnitude halves become signed integers, then truncated to 24 bits.
    function automatic logic [WW-1:0] model_word(input logic [WW-1:0] w);
`ifdef FFT_RD_TWOS_EN
        int re;
        int im;
        re = int'(w[46:24]);
        im = int'(w[22:0]);
        if (w[47]) re = -re;
        if (w[23]) im = -im;
        return {re[23:0], im[23:0]};
`else
        return w;
`endif
    endfunction

    task automatic rand_bus();
        logic [63:0] r;
        for (int k = 0; k < NPTS; k++) begin
            r = {$urandom(), $urandom()};
            xw_flat[k*WW +: WW] = r[WW-1:0];
        end
    endtask

    task automatic prep_exp();
        for (int k = 0; k < NPTS; k++) exp_w[k] = model_word(xw_flat[k*WW +: WW]);
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_rise", 64'(busy), 64'(1));
        chk("valid_after_rise", 64'(m_valid), 64'(0));
        for (int i = 1; i < FFT_LAT; i++) begin
            tick();
            chk("valid_during_wait", 64'(m_valid), 64'(0));
        end
        tick();
        chk("valid_at_capture", 64'(m_valid), 64'(1));
        chk("index_at_capture", 64'(m_index), 64'(0));
    endtask

    // rmode 0: always ready; rmode 1: ready pattern 1-0-0-1. ovr_at >= 0 raises start at that bin.
    task automatic consume(input int rmode, input int ovr_at, input bit chg);
        int n = 0;
        int cyc = 0;
        int ovr_seen = 0;
        while (n < NPTS && cyc < 400) begin
            m_ready = (rmode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (ovr_at >= 0 && n == ovr_at) start = 1'b1;
            if (chg && cyc == 1) rand_bus();
            if (overrun) ovr_seen++;
            chk("busy_in_stream", 64'(busy), 64'(1));
            chk("valid_held", 64'(m_valid), 64'(1));
            if (m_valid) begin
                chk("data", 64'(m_data), 64'(exp_w[n]));
                chk("index", 64'(m_index), 64'(n));
                chk("last", 64'(m_last), 64'(n == NPTS - 1));
                obs_w[n] = m_data;
                if (m_ready) n++;
            end
            tick();
            cyc++;
        end
        chk("accept_count", 64'(n), 64'(NPTS));
        if (rmode == 0) chk("stream_cycles", 64'(cyc), 64'(NPTS));
        if (overrun) ovr_seen++;
        chk("valid_after_last", 64'(m_valid), 64'(0));
        chk("busy_after_last", 64'(busy), 64'(0));
        chk("overrun_pulses", 64'(ovr_seen), 64'((ovr_at >= 0) ? 1 : 0));
        m_ready = 1'b0;
    endtask

    initial begin
        int cnt;
        rst_n   = 1'b0;
        start   = 1'b0;
        m_ready = 1'b0;
        xw_flat = '0;
        #23;
        chk("rst_valid", 64'(m_valid), 64'(0));
        chk("rst_data", 64'(m_data), 64'(0));
        chk("rst_index", 64'(m_index), 64'(0));
        chk("rst_last", 64'(m_last), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_overrun", 64'(overrun), 64'(0));
        rst_n = 1'b1;
        tick();
        tick();

        // Basic frame: word k = {24'h0, k}
        for (int k = 0; k < NPTS; k++) xw_flat[k*WW +: WW] = {24'h000000, 24'(k)};
        prep_exp();
        start_frame();
        consume(0, -1, 1'b0);
        for (int k = 0; k < NPTS; k++) begin
            chk("basic_low_half", 64'(obs_w[k][23:0]), 64'(k));
        end
        tick();

        // Real FFT bin 0 for x=[2,2,2,0..]: +6.0
        rand_bus();
        xw_flat[0 +: WW] = 48'h001800_000000;
        prep_exp();
        start_frame();
        consume(0, -1, 1'b0);
        chk("fft_bin0", 64'(obs_w[0]), 64'(48'h001800_000000));
        tick();

        // Backpressure, bus changed after capture, conversion vectors
        rand_bus();
        xw_flat[3*WW +: WW] = 48'h800400_000400;
        xw_flat[4*WW +: WW] = 48'h800000_800000;
        prep_exp();
        start_frame();
        consume(1, -1, 1'b1);
`ifdef FFT_RD_TWOS_EN
        chk("conv_word3", 64'(obs_w[3]), 64'(48'hFFFC00_000400));
        chk("conv_word4", 64'(obs_w[4]), 64'(48'h000000_000000));
`else
        chk("raw_word3", 64'(obs_w[3]), 64'(48'h800400_000400));
        chk("raw_word4", 64'(obs_w[4]), 64'(48'h800000_800000));
`endif
        tick();

        // Overrun at bin 10, start then held high: exactly one frame
        rand_bus();
        prep_exp();
        start_frame();
        consume(0, 10, 1'b0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (m_valid || busy) cnt++;
        end
        chk("held_start_one_frame", 64'(cnt), 64'(0));
        start = 1'b0;
        tick();

        // Reset mid-stream at bin 5
        rand_bus();
        prep_exp();
        start_frame();
        m_ready = 1'b1;
        cnt = 0;
        while (m_index != 5 && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("reached_bin5", 64'(m_index), 64'(5));
        rst_n = 1'b0;
        #2;
        chk("midrst_valid", 64'(m_valid), 64'(0));
        chk("midrst_data", 64'(m_data), 64'(0));
        chk("midrst_index", 64'(m_index), 64'(0));
        chk("midrst_last", 64'(m_last), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_overrun", 64'(overrun), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (m_valid || busy) cnt++;
        end
        chk("quiet_after_reset", 64'(cnt), 64'(0));
        m_ready = 1'b0;

        // Recovery frame with backpressure
        rand_bus();
        prep_exp();
        start_frame();
        consume(1, -1, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
